// File: rtl/muldiv_seq_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add over MUL_BITS_PER_CYCLE multiplier bits per cycle.
// Divide is restoring division, one quotient bit per cycle.
// A one-cycle FIX state applies sign correction and commits HI/LO.
// Optional feature macro: MULDIV_MADD_EN enables op 6/7 (MADD/MADDU).
// Without it, op 6/7 are ignored and the accumulate adder is not built.
module muldiv_seq_unit #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] HI_out,
  output logic [DATA_WIDTH-1:0] LO_out
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned W2    = 2 * DATA_WIDTH;
  localparam int unsigned K     = MUL_BITS_PER_CYCLE;
  localparam int unsigned NM    = DATA_WIDTH / MUL_BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  // Kind of the in-flight operation, consulted in FIX.
  localparam logic [1:0] K_MUL  = 2'd0;
  localparam logic [1:0] K_MADD = 2'd1;
  localparam logic [1:0] K_DIV  = 2'd2;

  logic [1:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [W2-1:0]    acc_q, acc_nxt;
  logic [W2-1:0]    mcand_q, mcand_nxt;
  logic [W-1:0]     mplier_q, mplier_nxt;
  logic [W-1:0]     rem_q, rem_nxt;
  logic [W-1:0]     quot_q, quot_nxt;
  logic [W-1:0]     dvsr_q, dvsr_nxt;
  logic             neg_q, neg_nxt;
  logic             neg_rem_q, neg_rem_nxt;
  logic             dz_q, dz_nxt;
  logic [1:0]       kind_q, kind_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             dbz_q, dbz_nxt;
  logic [W-1:0]     hi_q, hi_nxt;
  logic [W-1:0]     lo_q, lo_nxt;

  logic             op_signed;
  logic             a_neg, b_neg, b_zero;
  logic [W-1:0]     a_mag, b_mag;
  logic             mul_load;
  logic [W2-1:0]    mul_partial;
  logic [W:0]       div_shift, div_diff;
  logic             div_ge;
  logic [W2-1:0]    prod_fix;
  logic [W-1:0]     quot_fix, rem_fix;
`ifdef MULDIV_MADD_EN
  logic [W2-1:0]    madd_sum;
`endif

  // Operand decode: signedness and magnitudes taken at the start edge.
  assign op_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
  assign a_neg     = A[W-1];
  assign b_neg     = B[W-1];
  assign b_zero    = (B == '0);
  assign a_mag     = (op_signed && a_neg) ? (~A + W'(1)) : A;
  assign b_mag     = (op_signed && b_neg) ? (~B + W'(1)) : B;

  // Sum of the multiplicand copies selected by this cycle's multiplier bits.
  always_comb begin
    mul_partial = '0;
    for (int unsigned j = 0; j < K; j++) begin
      if (mplier_q[j]) mul_partial = mul_partial + (mcand_q << j);
    end
  end

  // Restoring division trial subtract.
  assign div_shift = {rem_q, quot_q[W-1]};
  assign div_diff  = div_shift - {1'b0, dvsr_q};
  assign div_ge    = ~div_diff[W];

  // Sign correction applied in FIX.
  assign prod_fix = neg_q     ? (~acc_q  + W2'(1)) : acc_q;
  assign quot_fix = neg_q     ? (~quot_q + W'(1))  : quot_q;
  assign rem_fix  = neg_rem_q ? (~rem_q  + W'(1))  : rem_q;
`ifdef MULDIV_MADD_EN
  assign madd_sum = {hi_q, lo_q} + prod_fix;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    acc_nxt     = acc_q;
    mcand_nxt   = mcand_q;
    mplier_nxt  = mplier_q;
    rem_nxt     = rem_q;
    quot_nxt    = quot_q;
    dvsr_nxt    = dvsr_q;
    neg_nxt     = neg_q;
    neg_rem_nxt = neg_rem_q;
    dz_nxt      = dz_q;
    kind_nxt    = kind_q;
    done_nxt    = 1'b0;
    dbz_nxt     = 1'b0;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    mul_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: begin
              hi_nxt   = A;
              done_nxt = 1'b1;
            end
            OP_MTLO: begin
              lo_nxt   = A;
              done_nxt = 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              kind_nxt = K_MUL;
              mul_load = 1'b1;
            end
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU: begin
              kind_nxt = K_MADD;
              mul_load = 1'b1;
            end
`else
            OP_MADD, OP_MADDU: begin
              // Illegal without the accumulate feature: request is dropped.
            end
`endif
            OP_DIV, OP_DIVU: begin
              kind_nxt    = K_DIV;
              neg_nxt     = op_signed && (a_neg ^ b_neg);
              neg_rem_nxt = op_signed && a_neg;
              if (b_zero) begin
                // Divide by zero skips iteration; quot holds raw A for HI.
                dz_nxt    = 1'b1;
                quot_nxt  = A;
                cnt_nxt   = '0;
                state_nxt = S_FIX;
              end else begin
                dz_nxt    = 1'b0;
                rem_nxt   = '0;
                quot_nxt  = a_mag;
                dvsr_nxt  = b_mag;
                cnt_nxt   = CNT_W'(W - 1);
                state_nxt = S_DIV;
              end
            end
          endcase
          if (mul_load) begin
            neg_nxt     = op_signed && (a_neg ^ b_neg);
            neg_rem_nxt = 1'b0;
            dz_nxt      = 1'b0;
            acc_nxt     = '0;
            mcand_nxt   = W2'(a_mag);
            mplier_nxt  = b_mag;
            cnt_nxt     = CNT_W'(NM - 1);
            state_nxt   = S_MUL;
          end
        end
      end

      S_MUL: begin
        acc_nxt    = acc_q + mul_partial;
        mcand_nxt  = mcand_q << K;
        mplier_nxt = mplier_q >> K;
        if (cnt_q == '0) state_nxt = S_FIX;
        else             cnt_nxt   = cnt_q - CNT_W'(1);
      end

      S_DIV: begin
        rem_nxt  = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
        quot_nxt = {quot_q[W-2:0], div_ge};
        if (cnt_q == '0) state_nxt = S_FIX;
        else             cnt_nxt   = cnt_q - CNT_W'(1);
      end

      S_FIX: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        done_nxt  = 1'b1;
        dbz_nxt   = dz_q;
        if (dz_q) begin
          hi_nxt = quot_q;
          lo_nxt = '1;
        end else if (kind_q == K_DIV) begin
          hi_nxt = rem_fix;
          lo_nxt = quot_fix;
        end
`ifdef MULDIV_MADD_EN
        else if (kind_q == K_MADD) begin
          {hi_nxt, lo_nxt} = madd_sum;
        end
`endif
        else begin
          {hi_nxt, lo_nxt} = prod_fix;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // Datapath and output registers; reset discards any partial result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      kind_q    <= K_MUL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_nxt;
      acc_q     <= acc_nxt;
      mcand_q   <= mcand_nxt;
      mplier_q  <= mplier_nxt;
      rem_q     <= rem_nxt;
      quot_q    <= quot_nxt;
      dvsr_q    <= dvsr_nxt;
      neg_q     <= neg_nxt;
      neg_rem_q <= neg_rem_nxt;
      dz_q      <= dz_nxt;
      kind_q    <= kind_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      dbz_q     <= dbz_nxt;
      hi_q      <= hi_nxt;
      lo_q      <= lo_nxt;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign HI_out      = hi_q;
  assign LO_out      = lo_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit (default parameters).
// Expected HI/LO come from plain 64-bit arithmetic; latency from the op class.
`timescale 1ns/1ps
module tb_muldiv_seq_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned NM = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done, div_by_zero;
  logic [W-1:0] HI_out, LO_out;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] mdl_hi = '0;
  logic [W-1:0] mdl_lo = '0;

  muldiv_seq_unit #(
    .DATA_WIDTH        (W),
    .MUL_BITS_PER_CYCLE(1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .HI_out     (HI_out),
    .LO_out     (LO_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural result {HI,LO} of one operation.
  function automatic logic [63:0] model_hilo(input logic [2:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] hi,
                                             input logic [W-1:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_MADD:  p = {hi, lo} + 64'(sa * sb);
      OP_MADDU: p = {hi, lo} + {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == '0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == '0) p = {a, 32'hFFFF_FFFF};
        else         p = {a % b, a / b};
      end
      OP_MTHI: p = {a, lo};
      default: p = {hi, a};
    endcase
    return p;
  endfunction

  // Cycle (counting the cycle after the start edge as 1) in which done is high.
  function automatic int exp_lat(input logic [2:0] o, input logic [W-1:0] b);
    if (o == OP_MTHI || o == OP_MTLO)              return 1;
    if ((o == OP_DIV || o == OP_DIVU) && b == '0)  return 2;
    if (o == OP_DIV || o == OP_DIVU)               return int'(W) + 2;
    return int'(NM) + 2;
  endfunction

  // Issue one legal op; optionally pulse an MTHI start while busy.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    logic [63:0] exp;
    int          lat, n;
    logic [W-1:0] hi0, lo0;
    exp = model_hilo(o, a, b, mdl_hi, mdl_lo);
    lat = exp_lat(o, b);
    hi0 = mdl_hi;
    lo0 = mdl_lo;
    op = o; A = a; B = b; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    op = 3'($urandom);
    A  = $urandom;
    B  = $urandom;
    n  = 1;
    if (lat > 1) begin
      check("busy_in_flight", 64'(busy), 64'(1));
      check("hilo_stale", {HI_out, LO_out}, {hi0, lo0});
    end
    while (!done && n < 200) begin
      if (poke && n == 5) begin
        start = 1'b1; op = OP_MTHI; A = 32'hDEAD_BEEF;
      end
      @(posedge CLK); #1;
      start = 1'b0;
      n++;
    end
    check("latency", 64'(n), 64'(lat));
    check("hilo", {HI_out, LO_out}, exp);
    check("div_by_zero", 64'(div_by_zero), 64'((o == OP_DIV || o == OP_DIVU) && b == '0));
    check("busy_at_done", 64'(busy), 64'(0));
    mdl_hi = exp[63:32];
    mdl_lo = exp[31:0];
  endtask

  // Issue an op that must be ignored entirely.
  task automatic run_illegal(input logic [2:0] o);
    bit saw_busy, saw_done;
    saw_busy = 1'b0;
    saw_done = 1'b0;
    op = o; A = 32'd1; B = 32'd1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) saw_busy = 1'b1;
      if (done) saw_done = 1'b1;
      @(posedge CLK); #1;
    end
    check("illegal_busy", 64'(saw_busy), 64'(0));
    check("illegal_done", 64'(saw_done), 64'(0));
    check("illegal_hilo", {HI_out, LO_out}, {mdl_hi, mdl_lo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    RST = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_hilo", {HI_out, LO_out}, 64'd0);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_dbz", 64'(div_by_zero), 64'(0));
    RST = 1'b1;
    @(posedge CLK); #1;

    // Directed multiply / divide cases.
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("mult_lit", {HI_out, LO_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(OP_MULTU, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("multu_lit", {HI_out, LO_out}, 64'h0000_0006_FFFF_FFEB);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lit", {HI_out, LO_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_lit", {HI_out, LO_out}, 64'h0000_0002_0000_000E);
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, 1'b0);
    check("divu0_lit", {HI_out, LO_out}, 64'h0000_1234_FFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lit", {HI_out, LO_out}, 64'h0000_0000_8000_0000);
    run_op(OP_DIV, 32'h8000_0000, 32'd0, 1'b0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Reset in the tenth cycle of a divide.
    op = OP_DIV; A = 32'h1234_5678; B = 32'd3; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge CLK); #1;
    end
    RST = 1'b0;
    #1;
    check("midrst_hilo", {HI_out, LO_out}, 64'd0);
    check("midrst_busy", 64'(busy), 64'(0));
    mdl_hi = '0;
    mdl_lo = '0;
    @(posedge CLK); #1;
    RST = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      @(posedge CLK); #1;
    end
    check("midrst_no_done", 64'(seen_done), 64'(0));

    // mthi/mtlo, then a multiply with a start pulsed while busy.
    run_op(OP_MTHI, 32'hAAAA_5555, 32'd0, 1'b0);
    check("mthi_lit", 64'(HI_out), 64'hAAAA_5555);
    run_op(OP_MTLO, 32'h0000_0001, 32'd0, 1'b0);
    check("mtlo_lit", {HI_out, LO_out}, 64'hAAAA_5555_0000_0001);
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1);
    check("poke_lit", {HI_out, LO_out}, 64'hFFFF_FFFF_FFFF_FFEB);

    // Accumulate ops: functional when enabled, ignored otherwise.
    run_op(OP_MTHI, 32'd0, 32'd0, 1'b0);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    if (MADD_EN) begin
      run_op(OP_MADDU, 32'd1, 32'd1, 1'b0);
      check("maddu_lit", {HI_out, LO_out}, 64'h0000_0001_0000_0000);
      run_op(OP_MADD, 32'hFFFF_FFFF, 32'd5, 1'b0);
    end else begin
      run_illegal(OP_MADDU);
      run_illegal(OP_MADD);
    end

    // Randomized ops, back to back (each start coincides with the previous done).
    for (int i = 0; i < 60; i++) begin
      logic [2:0]   o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, MADD_EN ? 7 : 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(o, a, b, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, replacing the combinational mult/div plus GP_regs path.
- Computes signed and unsigned multiply and divide iteratively.
- Supports mthi/mtlo writes.
- Exposes a start/busy/done handshake so the control unit stalls on mfhi/mflo while an operation is in flight.
- Sits beside the ALU: operands come from register-file RD1/RD2, HI/LO feed the writeback mux.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width (even, at least 8).
- MUL_BITS_PER_CYCLE, 1, multiplier bits consumed per iteration (1, 2 or 4; must divide DATA_WIDTH).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- A  in  DATA_WIDTH  rs operand (multiplicand/dividend/mthi-mtlo source).
- B  in  DATA_WIDTH  rt operand (multiplier/divisor).
- busy  out  1  operation in flight; new starts ignored.
- done  out  1  one-cycle pulse, first cycle new HI/LO visible.
- div_by_zero  out  1  one-cycle pulse coincident with done for DIV/DIVU with B=0.
- HI_out  out  DATA_WIDTH  HI register.
- LO_out  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (RST=0, async): state=IDLE; HI_out, LO_out = 0; busy, done, div_by_zero = 0; counter = 0. A reset mid-operation aborts it and discards all partial results.
- States: IDLE, MUL, DIV, FIX.
- In IDLE, start=1 with op=MTHI/MTLO: A is written to HI/LO at that edge. busy stays 0; done pulses in the next cycle.
- In IDLE, start=1 with MULT/MULTU/MADD/MADDU: operand magnitudes are latched (signed ops take abs value; sign flag = A[msb]^B[msb]). Go to MUL for NM = DATA_WIDTH/MUL_BITS_PER_CYCLE cycles of shift-add into a 2*DATA_WIDTH accumulator.
- In IDLE, start=1 with DIV/DIVU and B≠0: latch magnitudes. Go to DIV for DATA_WIDTH cycles of restoring division, one quotient bit per cycle.
- In IDLE, start=1 with DIV/DIVU and B=0: go straight to FIX. Result HI=A, LO=all ones; div_by_zero pulses with done.
- FIX (one cycle): sign correction, then HI/LO written at the FIX→IDLE edge.
  - Product negated if the sign flag is set.
  - Quotient negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - MADD/MADDU add the corrected product to {HI,LO}, modulo 2^(2*DATA_WIDTH).
- done is high in the cycle after the FIX→IDLE edge.
- busy is high from the cycle after the start edge through the FIX cycle inclusive.
- Latency from start edge to done: multiply NM+2 cycles, divide DATA_WIDTH+2 cycles, divide-by-zero 2 cycles.
- HI/LO hold their old values until the FIX write, so mfhi during busy returns stale data; the control unit must stall.
- start while busy=1: ignored, with no effect on the current operation.
- start together with done: accepted normally.
- Overflow case DIV of the most negative value by -1: LO=most negative value, HI=0; no flag raised.
- Operands A and B are only sampled at the start edge; later changes have no effect.

Optional Feature:
MULDIV_MADD_EN
- Defined: op 6/7 perform MADD/MADDU as above.
- Undefined: op 6/7 are illegal. start is ignored, busy stays 0, HI/LO are unchanged and no done pulse occurs. Accumulator adder logic is omitted.

Test Plan:
- Reset mid-DIV (RST low on cycle 10 after start) -> HI=LO=0, busy=0 immediately, no done afterwards.
- MULT A=7, B=0xFFFFFFFD (-3), defaults -> done exactly 34 cycles after start edge, HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU of the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV A=0xFFFFFFF9 (-7), B=2 -> done after 34 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=0x0000000E, HI=0x00000002.
- DIVU A=0x1234, B=0 -> done after 2 cycles with div_by_zero=1, HI=0x00001234, LO=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0xAAAA5555 then MTLO A=0x1; start pulsed during busy of a MULT -> MTHI/MTLO land immediately with busy=0, the during-busy start is ignored, and MULT result and done timing are unchanged.
- MADD_EN: preload HI=0, LO=0xFFFFFFFF via MTLO, MADDU A=1, B=1 -> HI=1, LO=0. With macro undefined, the same op leaves HI/LO unchanged with no done.
